maxnet_ctrl: RTL

Sequencing controller for the four-neuron MaxNet winner-take-all datapath. It takes four 32-bit IEEE-754 single-precision activations over a valid/ready stream and presents them to the datapath on `x1..x4`. It drives the per-neuron feedback selects `m1..m4` through one load cycle and then the iteration phase, and monitors the datapath's `done`. When the datapath converges, the controller returns the surviving activation over a valid/ready result port. A bounded iteration count converts a non-converging run into a flagged error response.

---
 rtl/maxnet_pkg.sv | 9 +
 rtl/maxnet_in_buf.sv | 44 ++++
 rtl/maxnet_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/maxnet_pkg.sv
// Shared types and constants for the MaxNet controller and datapath.
package maxnet_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, ITER, RESP} state_t;

  localparam logic [31:0] FP_ONE     = 32'h3F800000;
  localparam logic [31:0] FP_EPS_NEG = 32'hBE4CCCCD;

endpackage

// File: rtl/maxnet_in_buf.sv
// Collects four activation words into x1..x4; registers update on the accept edge.
// Accepts only while en is high; full_pulse flags the 4th accept combinationally.
module maxnet_in_buf
  import maxnet_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              full_pulse,
  output logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] x2,
  output logic [DATA_W-1:0] x3,
  output logic [DATA_W-1:0] x4
);

  logic [1:0] idx;
  logic       accept;

  assign accept     = en & in_valid;
  assign full_pulse = accept & (idx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= 2'd0;
      x1  <= '0;
      x2  <= '0;
      x3  <= '0;
      x4  <= '0;
    end else if (accept) begin
      case (idx)
        2'd0: x1 <= in_data;
        2'd1: x2 <= in_data;
        2'd2: x3 <= in_data;
        default: x4 <= in_data;
      endcase
      idx <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/maxnet_ctrl.sv
// MaxNet sequencer: collect 4 words, 1 load cycle, iterate until done or MAX_ITER, then respond.
// Result is held in RESP until out_ready; in_ready is high only in IDLE.
module maxnet_ctrl
  import maxnet_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MAX_ITER = 64,
  parameter int CNT_W    = $clog2(MAX_ITER + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] x2,
  output logic [DATA_W-1:0] x3,
  output logic [DATA_W-1:0] x4,
  output logic              m1,
  output logic              m2,
  output logic              m3,
  output logic              m4,
  input  logic              done,
  input  logic [DATA_W-1:0] dp_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_ITER - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] out_data_nxt;
  logic              out_err_nxt;
  logic              m_q;
  logic              full_pulse;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign m1       = m_q;
  assign m2       = m_q;
  assign m3       = m_q;
  assign m4       = m_q;

  maxnet_in_buf #(.DATA_W(DATA_W)) u_in_buf (
    .clk        (clk),
    .rst        (rst),
    .en         (in_ready),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .full_pulse (full_pulse),
    .x1         (x1),
    .x2         (x2),
    .x3         (x3),
    .x4         (x4)
  );

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    out_data_nxt = out_data;
    out_err_nxt  = out_err;
    case (state)
      IDLE: if (full_pulse) state_nxt = LOAD;
      LOAD: begin
        cnt_nxt   = '0;
        state_nxt = ITER;
      end
      ITER: begin
        cnt_nxt = cnt + 1'b1;
        // The first ITER cycle is the datapath settling cycle, so done is not trusted yet.
        if ((cnt != '0) && done) begin
          out_data_nxt = dp_out;
          out_err_nxt  = 1'b0;
          state_nxt    = RESP;
        end else if (cnt == CNT_LAST) begin
          out_data_nxt = '0;
          out_err_nxt  = 1'b1;
          state_nxt    = RESP;
        end
      end
      RESP: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      m_q       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      out_valid <= (state_nxt == RESP);
      out_data  <= out_data_nxt;
      out_err   <= out_err_nxt;
      m_q       <= (state_nxt == ITER) || (state_nxt == RESP);
    end
  end

endmodule
